// File: rtl/prog_fetch_ctrl_if.sv
// prog_fetch_ctrl_if: fetch-controller bus between the sequencer (master) and the PC/fetch block (slave)
// Controls (master -> slave): pc_ld, pc_inc, pc_mux_sel, from_immed, from_stack, stall, flush, push, pop
// Status (slave -> master): prog_addr, pc_count, ir_addr, ir_valid, pc_wrap, stk_err
interface prog_fetch_ctrl_if #(parameter int ADDR_W = 10);
    logic              pc_ld;
    logic              pc_inc;
    logic [1:0]        pc_mux_sel;
    logic [ADDR_W-1:0] from_immed;
    logic [ADDR_W-1:0] from_stack;
    logic              stall;
    logic              flush;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] prog_addr;
    logic [ADDR_W-1:0] pc_count;
    logic [ADDR_W-1:0] ir_addr;
    logic              ir_valid;
    logic              pc_wrap;
    logic              stk_err;
    modport master (
        output pc_ld, pc_inc, pc_mux_sel, from_immed, from_stack, stall, flush, push, pop,
        input  prog_addr, pc_count, ir_addr, ir_valid, pc_wrap, stk_err
    );
    modport slave (
        input  pc_ld, pc_inc, pc_mux_sel, from_immed, from_stack, stall, flush, push, pop,
        output prog_addr, pc_count, ir_addr, ir_valid, pc_wrap, stk_err
    );
endinterface

// File: rtl/prog_fetch_ctrl.sv
// prog_fetch_ctrl: program counter and fetch tracker in front of the synchronous program ROM
// Ports: clk, rst_n (async active-low), bus (prog_fetch_ctrl_if.slave: next-PC controls in,
// prog_addr/pc_count/ir_addr/ir_valid/pc_wrap/stk_err out).
// Optional macro PF_RET_STACK_EN: internal STACK_DEPTH-entry return stack replaces the from_stack port.
module prog_fetch_ctrl #(
    parameter int                ADDR_W      = 10,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
    parameter logic [ADDR_W-1:0] INTR_VEC    = '1,
    parameter int                STACK_DEPTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    prog_fetch_ctrl_if.slave  bus
);
    logic [ADDR_W-1:0] pc, pc_next, pc_plus1, ret_addr, ir_addr;
    logic              ir_valid, pc_wrap, stk_err, inc_go;
    assign pc_plus1 = pc + ADDR_W'(1);
    assign inc_go   = !bus.pc_ld && bus.pc_inc && !bus.stall;
    assign pc_next  = bus.pc_ld ? (bus.pc_mux_sel == 2'd0 ? bus.from_immed :
                                   bus.pc_mux_sel == 2'd1 ? ret_addr :
                                   bus.pc_mux_sel == 2'd2 ? INTR_VEC : pc) :
                      inc_go ? pc_plus1 : pc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_ADDR;
            ir_addr  <= RESET_ADDR;
            ir_valid <= 1'b0;
            pc_wrap  <= 1'b0;
        end else begin
            pc      <= pc_next;
            pc_wrap <= inc_go && (pc == '1);
            // The ROM output register re-reads the same address while stalled, so tracking freezes too
            if (!bus.stall) begin
                ir_addr  <= pc;
                ir_valid <= !bus.flush;
            end else if (bus.flush) begin
                ir_valid <= 1'b0;
            end
        end
    end
`ifdef PF_RET_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);
    logic [ADDR_W-1:0] stk [STACK_DEPTH];
    logic [SP_W-1:0]   sp, top;
    logic              empty, full;
    logic              unused_stack_port;
    assign top      = sp - SP_W'(1);
    assign empty    = (sp == '0);
    assign full     = (sp == SP_W'(STACK_DEPTH));
    assign ret_addr = empty ? '0 : stk[top[IDX_W-1:0]];
    assign unused_stack_port = &{1'b0, bus.from_stack};
    always_ff @(posedge clk) begin
        if (bus.push && bus.pop && !empty)
            stk[top[IDX_W-1:0]] <= pc_plus1;
        else if (bus.push && !bus.pop && !full)
            stk[sp[IDX_W-1:0]] <= pc_plus1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp      <= '0;
            stk_err <= 1'b0;
        end else if (bus.push && !bus.pop) begin
            if (full) stk_err <= 1'b1;
            else      sp      <= sp + SP_W'(1);
        end else if (bus.pop && !bus.push) begin
            if (empty) stk_err <= 1'b1;
            else       sp      <= top;
        end else if (bus.push && bus.pop && empty) begin
            // Replacing the top of an empty stack is an underflow
            stk_err <= 1'b1;
        end
    end
`else
    logic unused_stack_ctl;
    assign ret_addr         = bus.from_stack;
    assign stk_err          = 1'b0;
    assign unused_stack_ctl = &{1'b0, bus.push, bus.pop};
`endif
    assign bus.prog_addr = pc;
    assign bus.pc_count  = pc;
    assign bus.ir_addr   = ir_addr;
    assign bus.ir_valid  = ir_valid;
    assign bus.pc_wrap   = pc_wrap;
    assign bus.stk_err   = stk_err;
endmodule
